// File: rtl/fragment_hazard_scheduler_if.sv
// Fragment stream handshake bundle: valid/ready with last flag, framebuffer index and
// opaque sideband payload.
interface fragment_hazard_scheduler_if #(
  parameter int unsigned FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int unsigned PAYLOAD_WIDTH           = 128
);
  logic                               tvalid;
  logic                               tready;
  logic                               tlast;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] tindex;
  logic [PAYLOAD_WIDTH-1:0]           tpayload;

  modport master (output tvalid, tlast, tindex, tpayload, input tready);
  modport slave  (input tvalid, tlast, tindex, tpayload, output tready);
endinterface

// File: rtl/fragment_hazard_scheduler.sv
// Schedules fragments into the per-fragment pipeline, holding any fragment whose framebuffer
// index is still in flight (read but not yet written back), with drain/flush sequencing.
module fragment_hazard_scheduler #(
  parameter int unsigned FRAMEBUFFER_INDEX_WIDTH = 14,
  parameter int unsigned PAYLOAD_WIDTH           = 128,
  parameter int unsigned MAX_IN_FLIGHT           = 8,
  parameter int unsigned COUNTER_WIDTH           = 16
) (
  input  logic                               aclk,
  input  logic                               resetn,
  fragment_hazard_scheduler_if.slave         s_frag,
  fragment_hazard_scheduler_if.master        m_frag,
  input  logic                               fragmentProcessed,
  input  logic                               flush,
  output logic                               flushDone,
  input  logic                               clearStats,
  output logic [COUNTER_WIDTH-1:0]           hazardStallCount,
  output logic [$clog2(MAX_IN_FLIGHT):0]     inFlightCount,
  output logic                               retireError
);

  localparam int unsigned PtrWidth   = $clog2(MAX_IN_FLIGHT);
  localparam int unsigned CountWidth = PtrWidth + 1;

  typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

  state_e                             state_q;
  logic                               flush_done_q;
  logic                               retire_error_q;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_index_q [MAX_IN_FLIGHT];
  logic [MAX_IN_FLIGHT-1:0]           sb_valid_q;
  logic [PtrWidth-1:0]                wr_ptr_q;
  logic [PtrWidth-1:0]                rd_ptr_q;
  logic [CountWidth-1:0]              count_q;
  logic [COUNTER_WIDTH-1:0]           stall_count_q;
  logic                               m_valid_q;
  logic                               m_last_q;
  logic [FRAMEBUFFER_INDEX_WIDTH-1:0] m_index_q;
  logic [PAYLOAD_WIDTH-1:0]           m_payload_q;

  logic hit;
  logic hazard;
  logic full;
  logic out_free;
  logic ready;
  logic accept;
  logic pop;

  // Compare against start-of-cycle entries, so a same-cycle retire still blocks.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_IN_FLIGHT; i++) begin
      if (sb_valid_q[i] && (sb_index_q[i] == s_frag.tindex)) hit = 1'b1;
    end
  end

  assign hazard   = s_frag.tvalid && hit;
  assign full     = (count_q == CountWidth'(MAX_IN_FLIGHT));
  assign out_free = !m_valid_q || m_frag.tready;
  assign ready    = (state_q == StIdle) && !hazard && !full && out_free;
  assign accept   = s_frag.tvalid && ready;
  assign pop      = fragmentProcessed && (count_q != '0);

  assign s_frag.tready    = ready;
  assign m_frag.tvalid    = m_valid_q;
  assign m_frag.tlast     = m_last_q;
  assign m_frag.tindex    = m_index_q;
  assign m_frag.tpayload  = m_payload_q;
  assign flushDone        = flush_done_q;
  assign hazardStallCount = stall_count_q;
  assign inFlightCount    = count_q;
  assign retireError      = retire_error_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      sb_valid_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      retire_error_q <= 1'b0;
    end else begin
      if (pop) begin
        sb_valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q             <= rd_ptr_q + PtrWidth'(1);
      end
      if (accept) begin
        sb_valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q             <= wr_ptr_q + PtrWidth'(1);
      end
      if (accept && !pop) begin
        count_q <= count_q + CountWidth'(1);
      end else if (!accept && pop) begin
        count_q <= count_q - CountWidth'(1);
      end
      // A retire with nothing outstanding is dropped but remembered until reset.
      if (fragmentProcessed && (count_q == '0)) retire_error_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) sb_index_q[wr_ptr_q] <= s_frag.tindex;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (out_free) begin
      m_valid_q <= accept;
      if (accept) m_last_q <= s_frag.tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      m_index_q   <= s_frag.tindex;
      m_payload_q <= s_frag.tpayload;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      stall_count_q <= '0;
    end else if (clearStats) begin
      stall_count_q <= '0;
    end else if (hazard && (state_q == StIdle) && !(&stall_count_q)) begin
      stall_count_q <= stall_count_q + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (flush || (accept && s_frag.tlast)) state_q <= StDrain;
        end
        StDrain: begin
          if ((count_q == '0) && !m_valid_q) begin
            state_q      <= StDone;
            flush_done_q <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fragment_hazard_scheduler.md
Name: fragment_hazard_scheduler

Overview:
- Sits in front of the per-fragment (framebuffer read/test/blend/write-back) pipeline and schedules fragments into it.
- Tracks the framebuffer indices of fragments that are read but not yet written back (scoreboard). A fragment whose index hits an in-flight entry is held, which prevents read-after-write hazards on color, depth and stencil.
- Also provides drain/flush sequencing and hazard-stall statistics.

Parameters:
- FRAMEBUFFER_INDEX_WIDTH, 14: width of the framebuffer index.
- PAYLOAD_WIDTH, 128: opaque fragment sideband (color, depth, screen pos, keep), passed through unmodified.
- MAX_IN_FLIGHT, 8: scoreboard entries; power of two, at least 2; at least the downstream pipeline depth plus 1.
- COUNTER_WIDTH, 16: width of the stall statistics counter.

Ports:
- aclk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- s_frag_tvalid  in  1  upstream fragment valid
- s_frag_tready  out  1  upstream ready
- s_frag_tlast  in  1  last fragment of the stream
- s_frag_tindex  in  FRAMEBUFFER_INDEX_WIDTH  framebuffer index
- s_frag_tpayload  in  PAYLOAD_WIDTH  sideband
- m_frag_tvalid  out  1  to pipeline, registered
- m_frag_tready  in  1  pipeline ready / clock enable
- m_frag_tlast  out  1  registered
- m_frag_tindex  out  FRAMEBUFFER_INDEX_WIDTH  registered
- m_frag_tpayload  out  PAYLOAD_WIDTH  registered
- fragmentProcessed  in  1  retire pulse from pipeline write-back, one per fragment, in order
- flush  in  1  single-cycle request to drain
- flushDone  out  1  single-cycle pulse when drained
- clearStats  in  1  clears the statistics counter
- hazardStallCount  out  COUNTER_WIDTH  saturating count of hazard-stall cycles
- inFlightCount  out  clog2(MAX_IN_FLIGHT)+1  valid scoreboard entries
- retireError  out  1  sticky: retire received while scoreboard was empty

Behaviour:
- Reset (async assert, sync release):
  - m_frag_tvalid, m_frag_tlast, flushDone, retireError = 0.
  - hazardStallCount, inFlightCount = 0.
  - Scoreboard empty; FSM in IDLE.
  - m_frag_tindex and m_frag_tpayload are don't-care.
- Output register:
  - Loads when (!m_frag_tvalid || m_frag_tready) && accept.
  - Clears m_frag_tvalid when m_frag_tready is high and nothing is accepted.
  - Holds all m_* outputs while m_frag_tvalid && !m_frag_tready.
  - Latency from s to m is 1 cycle.
- hazard = s_frag_tvalid && (s_frag_tindex equals any valid scoreboard entry). The compare uses the state at the start of the cycle, so an entry retiring in the same cycle still blocks: one cycle of conservative extra stall.
- full = inFlightCount == MAX_IN_FLIGHT.
- accept = s_frag_tvalid && s_frag_tready.
- s_frag_tready = (state == IDLE) && !hazard && !full && (!m_frag_tvalid || m_frag_tready). It is combinational and may depend on s_frag_tvalid/s_frag_tindex. Upstream must not make tvalid depend on tready.
- Scoreboard:
  - Circular FIFO of indices with wrapping write/read pointers.
  - Push on accept; pop on fragmentProcessed.
  - Simultaneous push and pop: count unchanged, both pointers advance. This is legal when full, but a full scoreboard blocks accept, so it never occurs at full.
  - fragmentProcessed while empty: ignored, retireError <= 1. retireError clears only on reset.
- hazardStallCount:
  - +1 each cycle where s_frag_tvalid && hazard && state == IDLE.
  - Saturates at all-ones.
  - clearStats sets it to 0; clearStats has priority over the increment in the same cycle.
- FSM:
  - IDLE: flush=1 -> DRAIN. The fragment accepted in the same cycle as flush is accepted and tracked. An accepted fragment with s_frag_tlast=1 also -> DRAIN.
  - DRAIN: no accepts. When inFlightCount == 0 and m_frag_tvalid == 0 -> DONE.
  - DONE: flushDone = 1 for exactly one cycle -> IDLE.
  - flush while in DRAIN or DONE: ignored.
  - An empty scoreboard at flush gives DRAIN -> DONE on the next cycle, so flushDone arrives 2 cycles after flush.
- Width rules: index compare is exact over the full FRAMEBUFFER_INDEX_WIDTH; the payload is never inspected.

Test Plan:
- Stream of 16 fragments with distinct indices 0..15, m_frag_tready=1, retire 4 cycles after issue -> one accept per cycle, no stall, hazardStallCount=0, outputs delayed by 1 cycle.
- Index 5 issued, then index 5 again next cycle, retire at cycle 5 -> second fragment held with s_frag_tready=0 until the cycle after the retire, hazardStallCount equals the stall cycles (5).
- MAX_IN_FLIGHT=8, no retires, 10 distinct fragments -> 8 accepted, inFlightCount=8, tready=0. A retire pulse -> exactly one more accepted.
- m_frag_tready=0 for 3 cycles with the output loaded -> m_* outputs stable, no accepts; release -> pipeline resumes with no loss or duplication.
- flush with 3 in flight -> no accepts. flushDone pulses one cycle after the final retire and a zero-inFlight cycle; tlast accepted -> same drain.
- fragmentProcessed with empty scoreboard -> retireError=1 and count stays 0. Assert resetn low mid-stream -> all outputs reset immediately and asynchronously.
